traffic_phase_scheduler: RTL
============================

// Module: traffic_phase_scheduler
// PURPOSE
// - Actuated scheduler for the two-road intersection. Latches road-A, road-B and pedestrian calls,
//   then sequences green/yellow/all-red phases plus an all-red WALK phase.
// - Sits between the cleaned request pulses from the button shift-register cleaners and the
//   LED/7-segment emulation logic.
// - Consumes the shared 1 s tick from the top-level prescaler.
// PARAMETERS
// - MIN_GREEN  6  s; earliest green may end when an opposing or ped call is pending (1..15)
// - MAX_GREEN  9  s; latest green may end when an opposing call is pending (MIN_GREEN..15)
// - YELLOW_T   2  s; yellow duration (1..15)
// - ALL_RED_T  2  s; all-red clearance after yellow and after WALK (1..15)
// - WALK_T     5  s; pedestrian WALK duration (1..15)
// PORTS
// - CLK100MHZ   in   1  system clock, 100 MHz
// - reset       in   1  synchronous, active-high
// - tick        in   1  one-cycle strobe, once per second
// - req_a       in   1  road-A request level (cleaned)
// - req_b       in   1  road-B request level (cleaned)
// - req_ped     in   1  pedestrian request level (cleaned)
// - a_green, a_yellow, a_red   out  1 each  road-A lamps
// - b_green, b_yellow, b_red   out  1 each  road-B lamps
// - walk        out  1  pedestrian WALK lamp
// - phase_timer out  4  seconds in current state; 1 on entry
// - call_a, call_b, call_ped   out  1 each  latched pending calls
// - state_code  out  3  current state encoding, for display/debug
// BEHAVIOUR
// - Moore FSM. States: GREEN_A=0, YELLOW_A=1, RED_A=2, GREEN_B=3, YELLOW_B=4, RED_B=5,
//   WALK=6, WALK_CLR=7. Lamps decode combinationally from state.
// - Lamp decode: non-green road shows red; RED_x, WALK and WALK_CLR show both roads red;
//   walk=1 only in WALK.
// - Reset: state=RED_B, last_road=B, phase_timer=1, all calls=0.
//   Resulting outputs: a_red=b_red=1, all other lamps 0, walk=0.
// - Timer:
//   - Loads 1 on every state change.
//   - Otherwise increments on tick and saturates at 15.
// - Transitions:
//   - Evaluated only in a tick cycle; the state register updates on that same clock edge.
//   - The new state is visible the next cycle.
// - Call latches:
//   - call_x <= call_x | req_x, except forced 0 while in GREEN_x.
//   - call_ped <= call_ped | req_ped, except forced 0 while in WALK.
//   - A request coincident with the clear loses; the clear wins.
// - GREEN_x (opp = other road):
//   - pending = call_opp | call_ped.
//   - Go to YELLOW_x when pending AND (timer>=MAX_GREEN OR (timer>=MIN_GREEN AND !req_x)).
//   - No pending call: rest in green indefinitely; timer saturates at 15.
//   - On entry: last_road <= x.
// - YELLOW_x -> RED_x when timer>=YELLOW_T.
// - RED_x:
//   - When timer>=ALL_RED_T: go to WALK if call_ped, else GREEN_opp.
// - WALK -> WALK_CLR when timer>=WALK_T.
// - WALK_CLR:
//   - When timer>=ALL_RED_T: GREEN_opp(last_road) if call_opp, else GREEN_last_road.
// - Illegal state encoding: go to RED_B next cycle, timer=1.
// - Reset asserted mid-phase: the reset values above take effect on the next edge.
//   Pending calls are discarded.
// - Parameter legality is checked by elaboration-time assertion: MIN_GREEN<=MAX_GREEN,
//   all values 1..15.
// STRUCTURE
// - traffic_pkg:
//   - phase_t enum holding the 8 states with the encodings above.
//   - ON/OFF constants.
//   - road_t {ROAD_A, ROAD_B}.
// - One sub-module, traffic_phase_timer: 4-bit saturating seconds counter.
//   - Inputs: load (loads 1), tick.
//   - Output: count.
// - This top holds the FSM, call latches, last_road register and lamp decode.
// TESTING
// - Tick every 10 cycles in all scenarios.
// - Reset: hold reset 3 cycles, no requests.
//   -> a_red=b_red=1, timer=1; GREEN_A entered after the 2nd tick.
//   -> Then rests in GREEN_A; timer saturates at 15 and stays.
// - Gap-out: in GREEN_A, pulse req_b at timer=3, req_a low.
//   -> YELLOW_A on the tick where timer=6.
//   -> RED_A 2 s later, GREEN_B 2 s after that; call_b clears in GREEN_B.
// - Max-out: in GREEN_A, hold req_a high and pulse req_b.
//   -> Green held until the tick where timer=9, then YELLOW_A.
// - Ped: in GREEN_B with no road calls, pulse req_ped.
//   -> YELLOW_B at timer=6, then RED_B, then WALK (walk=1 for 5 s).
//   -> Then WALK_CLR 2 s, then GREEN_B (no call_a pending).
// - Coincidence: req_a asserted every cycle during GREEN_A.
//   -> call_a stays 0 throughout.
//   -> Same-cycle req_ped and reset -> call_ped=0 after the edge.
// - Mid-phase reset during YELLOW_A with call_ped=1.
//   -> State RED_B, all calls 0, timer=1 on the next cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and constants for the two-road intersection phase scheduler.
//   phase_t   : FSM state encoding, also exported on state_code for the display
//   road_t    : which road held green most recently
//   ON / OFF  : lamp drive levels
//   TIMER_MAX : saturation value of the 4-bit seconds counter
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [2:0] {
    GREEN_A  = 3'd0,
    YELLOW_A = 3'd1,
    RED_A    = 3'd2,
    GREEN_B  = 3'd3,
    YELLOW_B = 3'd4,
    RED_B    = 3'd5,
    WALK     = 3'd6,
    WALK_CLR = 3'd7
  } phase_t;

  typedef enum logic {
    ROAD_A = 1'b0,
    ROAD_B = 1'b1
  } road_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic [3:0] TIMER_MAX = 4'd15;

endpackage

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
// Seconds spent in the current phase. Loading takes priority over counting, so
// a tick in the same cycle as a phase change still yields 1 on entry.
// Ports:
//   clk   in  1  system clock
//   load  in  1  force count to 1 on the next edge (phase change or reset)
//   tick  in  1  one-cycle strobe, once per second
//   count out 4  seconds in phase, saturates at 15
// -----------------------------------------------------------------------------
module traffic_phase_timer
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       load,
  input  logic       tick,
  output logic [3:0] count
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = 4'd1;
    end else if (tick && (count_q != TIMER_MAX)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler
// Actuated two-road scheduler: latches road and pedestrian calls, sequences
// green / yellow / all-red per road and an all-red WALK phase with clearance.
// Ports:
//   CLK100MHZ                 in   system clock
//   reset                     in   synchronous, active-high
//   tick                      in   1 s strobe from the shared prescaler
//   req_a, req_b, req_ped     in   cleaned request levels
//   a_green/a_yellow/a_red    out  road-A lamps
//   b_green/b_yellow/b_red    out  road-B lamps
//   walk                      out  pedestrian WALK lamp
//   phase_timer               out  seconds in current phase (1 on entry)
//   call_a, call_b, call_ped  out  latched pending calls
//   state_code                out  current phase encoding
// -----------------------------------------------------------------------------
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 6,
  parameter int MAX_GREEN = 9,
  parameter int YELLOW_T  = 2,
  parameter int ALL_RED_T = 2,
  parameter int WALK_T    = 5
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       req_ped,
  output logic       a_green,
  output logic       a_yellow,
  output logic       a_red,
  output logic       b_green,
  output logic       b_yellow,
  output logic       b_red,
  output logic       walk,
  output logic [3:0] phase_timer,
  output logic       call_a,
  output logic       call_b,
  output logic       call_ped,
  output logic [2:0] state_code
);

  if (MIN_GREEN < 1 || MIN_GREEN > 15 || MAX_GREEN < MIN_GREEN || MAX_GREEN > 15 ||
      YELLOW_T < 1 || YELLOW_T > 15 || ALL_RED_T < 1 || ALL_RED_T > 15 ||
      WALK_T < 1 || WALK_T > 15) begin : g_bad_params
    $error("traffic_phase_scheduler: timing parameter out of range");
  end

  localparam logic [3:0] MIN_G   = 4'(MIN_GREEN);
  localparam logic [3:0] MAX_G   = 4'(MAX_GREEN);
  localparam logic [3:0] YEL_T   = 4'(YELLOW_T);
  localparam logic [3:0] RED_T   = 4'(ALL_RED_T);
  localparam logic [3:0] WLK_T   = 4'(WALK_T);

  phase_t     state_q, state_d;
  road_t      last_road_q, last_road_d;
  logic       call_a_q, call_a_d;
  logic       call_b_q, call_b_d;
  logic       call_ped_q, call_ped_d;
  logic [3:0] timer;
  logic       timer_load;

  // Green ends on max-out, or on gap-out once the own road has stopped asking.
  function automatic logic green_done(input logic pending, input logic own_req,
                                      input logic [3:0] t);
    return pending && ((t >= MAX_G) || ((t >= MIN_G) && !own_req));
  endfunction

  traffic_phase_timer u_timer (
    .clk   (CLK100MHZ),
    .load  (timer_load),
    .tick  (tick),
    .count (timer)
  );

  // Any phase change (including reset) restarts the seconds count at 1.
  assign timer_load = reset || (state_d != state_q);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= RED_B;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GREEN_A:  if (tick && green_done(call_b_q || call_ped_q, req_a, timer)) state_d = YELLOW_A;
      YELLOW_A: if (tick && (timer >= YEL_T)) state_d = RED_A;
      RED_A:    if (tick && (timer >= RED_T)) state_d = call_ped_q ? WALK : GREEN_B;
      GREEN_B:  if (tick && green_done(call_a_q || call_ped_q, req_b, timer)) state_d = YELLOW_B;
      YELLOW_B: if (tick && (timer >= YEL_T)) state_d = RED_B;
      RED_B:    if (tick && (timer >= RED_T)) state_d = call_ped_q ? WALK : GREEN_A;
      WALK:     if (tick && (timer >= WLK_T)) state_d = WALK_CLR;
      WALK_CLR: begin
        // Serve the opposing road if it is waiting, otherwise return to the
        // road that was interrupted by the pedestrian phase.
        if (tick && (timer >= RED_T)) begin
          if (last_road_q == ROAD_A) state_d = call_b_q ? GREEN_B : GREEN_A;
          else                       state_d = call_a_q ? GREEN_A : GREEN_B;
        end
      end
      default:  state_d = RED_B;
    endcase
  end

  // A call is cleared while it is being served; the clear beats a new request.
  always_comb begin
    call_a_d    = (state_q == GREEN_A) ? OFF : (call_a_q   | req_a);
    call_b_d    = (state_q == GREEN_B) ? OFF : (call_b_q   | req_b);
    call_ped_d  = (state_q == WALK)    ? OFF : (call_ped_q | req_ped);
    last_road_d = last_road_q;
    if (state_d == GREEN_A)      last_road_d = ROAD_A;
    else if (state_d == GREEN_B) last_road_d = ROAD_B;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      call_a_q    <= OFF;
      call_b_q    <= OFF;
      call_ped_q  <= OFF;
      last_road_q <= ROAD_B;
    end else begin
      call_a_q    <= call_a_d;
      call_b_q    <= call_b_d;
      call_ped_q  <= call_ped_d;
      last_road_q <= last_road_d;
    end
  end

  always_comb begin
    a_green  = OFF;
    a_yellow = OFF;
    b_green  = OFF;
    b_yellow = OFF;
    walk     = OFF;
    case (state_q)
      GREEN_A:  a_green  = ON;
      YELLOW_A: a_yellow = ON;
      GREEN_B:  b_green  = ON;
      YELLOW_B: b_yellow = ON;
      WALK:     walk     = ON;
      default:  ;
    endcase
    a_red = ~(a_green | a_yellow);
    b_red = ~(b_green | b_yellow);
  end

  assign phase_timer = timer;
  assign call_a      = call_a_q;
  assign call_b      = call_b_q;
  assign call_ped    = call_ped_q;
  assign state_code  = state_q;

endmodule
